muldiv_hilo: RTL and testbench

- Multi-cycle multiply/divide unit for the single-cycle MIPS datapath. It executes MULT, MULTU, DIV and DIVU.
- It is the sequential counterpart of the combinational ALU. It receives operation codes and operands from the same control/register path and returns results into the HI/LO registers.
- Control issues a start pulse and stalls the PC while busy_o is high. MFHI/MFLO read hi_o/lo_o directly.

---
 rtl/muldiv_hilo.sv | 113 +++++++++++
 tb/tb_muldiv_hilo.sv | 127 ++++++++++++
 2 files changed

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: multi-cycle MULT/MULTU/DIV/DIVU unit writing HI/LO.
// Magnitudes are iterated for WIDTH cycles, and the sign is applied once in FIX.
module muldiv_hilo #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_is_div;
   logic               r_s1;
   logic               r_s2;
   logic               r_dz;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_acc_hi;
   logic [WIDTH-1:0]   r_acc_lo;
   logic [WIDTH-1:0]   r_src1;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_div_zero;
   logic               w_start;
   logic               w_s1;
   logic               w_s2;
   logic [WIDTH-1:0]   w_abs1;
   logic [WIDTH-1:0]   w_abs2;
   logic [WIDTH:0]     w_add;
   logic [WIDTH:0]     w_rsh;
   logic               w_ge;
   logic [WIDTH-1:0]   w_diff;
   logic [WIDTH-1:0]   w_nxt_hi;
   logic [WIDTH-1:0]   w_nxt_lo;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   assign busy_o     = (r_state == S_RUN) || (r_state == S_FIX);
   assign done_o     = (r_state == S_DONE);
   assign div_zero_o = r_div_zero;
   assign hi_o       = r_hi;
   assign lo_o       = r_lo;
   assign w_start = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_s1    = ~op_i[0] & src1_i[WIDTH-1];
   assign w_s2    = ~op_i[0] & src2_i[WIDTH-1];
   assign w_abs1  = w_s1 ? -src1_i : src1_i;
   assign w_abs2  = w_s2 ? -src2_i : src2_i;
   // Multiply step keeps the carry-out of P_hi+mcand as the bit shifted back in.
   assign w_add   = r_acc_lo[0] ? {1'b0, r_acc_hi} + {1'b0, r_a} : {1'b0, r_acc_hi};
   // Divide step: remainder stays below the divisor, so the difference fits WIDTH bits.
   assign w_rsh   = {r_acc_hi, r_acc_lo[WIDTH-1]};
   assign w_ge    = w_rsh >= {1'b0, r_a};
   assign w_diff  = w_rsh[WIDTH-1:0] - r_a;
   always_comb begin
      w_nxt_hi = r_is_div ? (w_ge ? w_diff : w_rsh[WIDTH-1:0]) : w_add[WIDTH:1];
      w_nxt_lo = r_is_div ? {r_acc_lo[WIDTH-2:0], w_ge} : {w_add[0], r_acc_lo[WIDTH-1:1]};
      w_prod   = (r_s1 ^ r_s2) ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
      w_quo    = (r_s1 ^ r_s2) ? -r_acc_lo : r_acc_lo;
      w_rem    = r_s1 ? -r_acc_hi : r_acc_hi;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_is_div   <= 1'b0;
         r_s1       <= 1'b0;
         r_s2       <= 1'b0;
         r_dz       <= 1'b0;
         r_a        <= '0;
         r_acc_hi   <= '0;
         r_acc_lo   <= '0;
         r_src1     <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_div_zero <= 1'b0;
      end else if (w_start) begin
         r_state  <= S_RUN;
         r_cnt    <= '0;
         r_is_div <= op_i[1];
         r_s1     <= w_s1;
         r_s2     <= w_s2;
         r_dz     <= op_i[1] & ~|src2_i;
         r_a      <= op_i[1] ? w_abs2 : w_abs1;
         r_acc_hi <= '0;
         r_acc_lo <= op_i[1] ? w_abs1 : w_abs2;
         r_src1   <= src1_i;
      end else if (r_state == S_RUN) begin
         r_acc_hi <= w_nxt_hi;
         r_acc_lo <= w_nxt_lo;
         r_cnt    <= r_cnt + 1'b1;
         r_state  <= (r_cnt == CNT_W'(WIDTH - 1)) ? S_FIX : S_RUN;
      end else if (r_state == S_FIX) begin
         r_state    <= S_DONE;
         r_div_zero <= r_dz;
         r_hi       <= r_dz ? r_src1 : (r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH]);
         r_lo       <= r_dz ? '1 : (r_is_div ? w_quo : w_prod[WIDTH-1:0]);
      end else if (r_state == S_DONE) begin
         r_state <= S_IDLE;
      end
   end
endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: directed scoreboard bench for muldiv_hilo.
module tb_muldiv_hilo;
   localparam int W = 32;
   typedef struct {
      string      tag;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic       dz;
   } exp_t;
   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         start_i = 1'b0;
   logic [1:0]   op_i = 2'b00;
   logic [W-1:0] src1_i = '0;
   logic [W-1:0] src2_i = '0;
   logic         busy_o;
   logic         done_o;
   logic         div_zero_o;
   logic [W-1:0] hi_o;
   logic [W-1:0] lo_o;
   int           checks = 0;
   int           failures = 0;
   exp_t         sb[$];
   muldiv_hilo #(.WIDTH(W), .CNT_W(6)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
      .src1_i(src1_i), .src2_i(src2_i), .busy_o(busy_o), .done_o(done_o),
      .div_zero_o(div_zero_o), .hi_o(hi_o), .lo_o(lo_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // Drives one start pulse across the next rising edge; the caller picks the moment.
   task automatic issue(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic push, input logic [W-1:0] eh,
                        input logic [W-1:0] el, input logic edz);
      exp_t e;
      start_i = 1'b1;
      op_i = op;
      src1_i = a;
      src2_i = b;
      if (push) begin
         e.tag = tag; e.hi = eh; e.lo = el; e.dz = edz;
         sb.push_back(e);
      end
      @(posedge clk_i);
      #1 start_i = 1'b0;
   endtask
   // Returns at the falling edge where done_o is seen, after scoring the result.
   task automatic wait_done(input int exp_busy);
      exp_t e;
      int   nb = 0;
      bit   seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk_i);
         if (done_o) seen = 1;
         else if (busy_o) nb++;
      end
      e = sb.pop_front();
      chk({e.tag, "_timeout"}, 64'(seen), 64'd1);
      chk({e.tag, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
      chk({e.tag, "_hi"}, 64'(hi_o), 64'(e.hi));
      chk({e.tag, "_lo"}, 64'(lo_o), 64'(e.lo));
      chk({e.tag, "_dz"}, 64'(div_zero_o), 64'(e.dz));
   endtask
   task automatic run(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                      input logic edz);
      @(negedge clk_i);
      issue(tag, op, a, b, 1'b1, eh, el, edz);
      wait_done(W + 1);
      @(negedge clk_i);
      chk({tag, "_done_pulse"}, {62'd0, done_o, busy_o}, 64'd0);
   endtask
   initial begin
      int ndone;
      #2;
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_dz", 64'(div_zero_o), 64'd0);
      chk("rst_hi", 64'(hi_o), 64'd0);
      chk("rst_lo", 64'(lo_o), 64'd0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      run("mult_m3x5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
      run("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0);
      run("mult_m1xm1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0);
      run("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run("div_7dm2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
      run("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      run("divu_5d0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
      run("multu_2x3", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
      run("div_m5d0", 2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
      run("div_minm1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
      @(negedge clk_i);
      issue("busy_ignore", 2'b01, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, 1'b0);
      repeat (10) @(negedge clk_i);
      issue("ignored", 2'b11, 32'd9, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("ignore_hold_lo", 64'(lo_o), 64'h80000000);
      wait_done(W + 1 - 10);
      issue("b2b_divu", 2'b11, 32'd9, 32'd3, 1'b1, 32'd0, 32'd3, 1'b0);
      chk("b2b_busy_next", {62'd0, busy_o, done_o}, 64'd2);
      wait_done(W + 1);
      @(negedge clk_i);
      issue("aborted", 2'b00, 32'd4, 32'd4, 1'b0, 32'd0, 32'd0, 1'b0);
      repeat (9) @(posedge clk_i);
      #3 rst_i = 1'b1;
      #1;
      chk("abort_outs", {busy_o, done_o, div_zero_o, hi_o, lo_o}, 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         if (done_o || busy_o) ndone++;
      end
      chk("abort_no_done", 64'(ndone), 64'd0);
      run("mult_4x4", 2'b00, 32'd4, 32'd4, 32'd0, 32'd16, 1'b0);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
